// File: rtl/ins_sequencer.sv
// rtl/ins_sequencer.sv - program buffer + instruction issue FSM driving master's ins/enable and capturing disp
// Optional single-step mode: define INS_SEQ_SINGLE_STEP_EN to add the step port and PAUSE state.
module ins_sequencer #(
  parameter int          DEPTH       = 16,
  parameter int          AW          = 4,
  parameter int          EXEC_CYCLES = 8,
  parameter logic [3:0]  HALT_OP     = 4'b1111
) (
  input  logic          boardclk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
`ifdef INS_SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic [15:0]   ins,
  output logic          enable,
  input  logic [15:0]   disp,
  input  logic [AW-1:0] res_addr,
  output logic [15:0]   res_data,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam int            CW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);
  localparam logic [AW-1:0] PC_LAST  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    CAPTURE = 3'd3,
    FIN     = 3'd4
`ifdef INS_SEQ_SINGLE_STEP_EN
    ,
    PAUSE   = 3'd5
`endif
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   ins_n;
  logic          enable_n;
  logic          capture;
  logic [15:0]   fetch_word;

  logic [15:0] mem [DEPTH];
  logic [15:0] res [DEPTH];

  assign fetch_word = mem[pc];
  assign res_data   = res[res_addr];
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

  // Program memory has no reset; only loadable while idle.
  always_ff @(posedge boardclk) begin
    if (!rst && state == IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge boardclk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      cnt    <= '0;
      ins    <= '0;
      enable <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        res[i] <= '0;
      end
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      cnt    <= cnt_n;
      ins    <= ins_n;
      enable <= enable_n;
      if (capture) begin
        res[pc] <= disp;
      end
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = cnt;
    ins_n    = ins;
    enable_n = enable;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          pc_n    = '0;
        end
      end
      FETCH: begin
        ins_n = fetch_word;
        if (fetch_word[15:12] == HALT_OP) begin
          state_n  = FIN;
          enable_n = 1'b0;
        end else begin
          state_n  = EXEC;
          enable_n = 1'b1;
          cnt_n    = '0;
        end
      end
      EXEC: begin
        if (cnt == CNT_LAST) begin
          state_n  = CAPTURE;
          enable_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        if (pc == PC_LAST) begin
          state_n = FIN;
        end else begin
`ifdef INS_SEQ_SINGLE_STEP_EN
          state_n = PAUSE;
`else
          state_n = FETCH;
          pc_n    = pc + AW'(1);
`endif
        end
      end
`ifdef INS_SEQ_SINGLE_STEP_EN
      PAUSE: begin
        if (step) begin
          state_n = FETCH;
          pc_n    = pc + AW'(1);
        end
      end
`endif
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ins_sequencer.sv
// tb/tb_ins_sequencer.sv - directed self-checking bench for ins_sequencer
// Single-step scenario is exercised when INS_SEQ_SINGLE_STEP_EN is defined.
module tb_ins_sequencer;

  logic        boardclk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic [15:0] ins;
  logic        enable;
  logic [15:0] disp;
  logic [3:0]  res_addr;
  logic [15:0] res_data;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
`ifdef INS_SEQ_SINGLE_STEP_EN
  logic        step;
`endif

  int tests  = 0;
  int failed = 0;
  int cyc;
  int en_cyc;
  logic [15:0] prog [16];

  ins_sequencer dut (
    .boardclk (boardclk),
    .rst      (rst),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start    (start),
`ifdef INS_SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .ins      (ins),
    .enable   (enable),
    .disp     (disp),
    .res_addr (res_addr),
    .res_data (res_data),
    .pc       (pc),
    .busy     (busy),
    .done     (done)
  );

  initial boardclk = 1'b0;
  always #5 boardclk = ~boardclk;

  // Master model: its result register tracks ~ins while enabled.
  initial disp = 16'h0000;
  always @(posedge boardclk) if (enable) disp <= ~ins;

  task automatic tick();
    @(posedge boardclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    prog[a]   = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic read_res(input logic [3:0] a, output logic [15:0] d);
    res_addr = a;
    #1;
    d = res_data;
  endtask

  // Runs from a start pulse until done; optionally disturbs with a write+start at cycle disturb_at.
  task automatic run(input int disturb_at, output int c, output int e);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    e = 0;
    while (c < 400) begin
      if (c == disturb_at) begin
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 16'hFFFF;
        start     = 1'b1;
      end
      tick();
      c++;
      prog_we = 1'b0;
      start   = 1'b0;
      if (enable) begin
        e++;
        check("ins_exec", ins, prog[pc]);
      end
      if (done) break;
    end
    check("done_reached", {15'd0, done}, 16'd1);
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'hABCD;
    start = 1'b1; res_addr = 4'd0;
`ifdef INS_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    repeat (2) tick();
    rst = 1'b0; prog_we = 1'b0; start = 1'b0;
`ifdef INS_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    check("rst_ins", ins, 16'h0000);
    check("rst_enable", {15'd0, enable}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_pc", {12'd0, pc}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      read_res(4'(i), r);
      check("rst_res", r, 16'h0000);
    end

`ifndef INS_SEQ_SINGLE_STEP_EN
    // Single instruction followed by HALT
    load(4'd0, 16'b0111000111110001);
    load(4'd1, 16'hF000);
    run(-1, cyc, en_cyc);
    check("single_cycles", 16'(cyc), 16'd11);
    check("single_en_cycles", 16'(en_cyc), 16'd8);
    check("single_pc", {12'd0, pc}, 16'd1);
    check("single_ins_kept", ins, 16'hF000);
    read_res(4'd0, r);
    check("single_res0", r, 16'h8E0E);
    read_res(4'd1, r);
    check("single_res1_untouched", r, 16'h0000);
    tick();
    check("single_done_pulse", {15'd0, done}, 16'd0);
    check("single_busy_drop", {15'd0, busy}, 16'd0);

    // Full buffer, no HALT
    for (int i = 0; i < 16; i++) load(4'(i), 16'h1000 + 16'(i));
    run(-1, cyc, en_cyc);
    check("full_cycles", 16'(cyc), 16'd160);
    check("full_en_cycles", 16'(en_cyc), 16'd128);
    check("full_pc", {12'd0, pc}, 16'd15);
    tick();
    check("full_done_pulse", {15'd0, done}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      read_res(4'(i), r);
      check("full_res", r, ~(16'h1000 + 16'(i)));
    end

    // Write and start issued while busy must be ignored
    run(3, cyc, en_cyc);
    check("guard_cycles", 16'(cyc), 16'd160);
    check("guard_en_cycles", 16'(en_cyc), 16'd128);
    check("guard_pc", {12'd0, pc}, 16'd15);
    tick();

    // Reset during 4th EXEC cycle of instruction 2
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_first_ins", ins, 16'h0000 ^ ins);
    repeat (24) tick();
    check("mid_enable_pre", {15'd0, enable}, 16'd1);
    check("mid_pc_pre", {12'd0, pc}, 16'd2);
    check("mid_ins_pre", ins, 16'h1002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_enable", {15'd0, enable}, 16'd0);
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_pc", {12'd0, pc}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      read_res(4'(i), r);
      check("mid_res_cleared", r, 16'h0000);
    end
    run(-1, cyc, en_cyc);
    check("rerun_cycles", 16'(cyc), 16'd160);
    check("rerun_en_cycles", 16'(en_cyc), 16'd128);
    read_res(4'd0, r);
    check("rerun_res0", r, 16'hEFFF);
    read_res(4'd2, r);
    check("rerun_res2", r, 16'hEFFD);
    read_res(4'd15, r);
    check("rerun_res15", r, 16'hEFF0);
`else
    // Single-step: three instructions then HALT
    load(4'd0, 16'h2000);
    load(4'd1, 16'h2001);
    load(4'd2, 16'h2002);
    load(4'd3, 16'hF000);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 3; k++) begin
      repeat (20) tick();
      check("ss_enable_paused", {15'd0, enable}, 16'd0);
      check("ss_pc_held", {12'd0, pc}, 16'(k));
      check("ss_busy", {15'd0, busy}, 16'd1);
      read_res(4'(k), r);
      check("ss_res", r, ~(16'h2000 + 16'(k)));
      step = 1'b1;
      tick();
      step = 1'b0;
      check("ss_pc_step", {12'd0, pc}, 16'(k + 1));
      tick();
      if (k < 2) begin
        check("ss_enable_exec", {15'd0, enable}, 16'd1);
        check("ss_ins", ins, 16'h2000 + 16'(k + 1));
        repeat (9) tick();
      end else begin
        check("ss_done", {15'd0, done}, 16'd1);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
